// File: rtl/rom_loader.sv
// -----------------------------------------------------------------------------
// rom_loader
//   Boot-time program loader. Receives a program image over a UART line
//   (8N1, LSB first) and writes it word by word into instruction memory,
//   holding the CPU in reset until the whole image has arrived.
//
//   Byte stream: count_hi, count_lo, then count words, each sent as hi, lo.
//   Counts above 32768 are clamped to 32768 (the full 15-bit address space).
//
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit (4..65535)
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   rx         in   UART receive line (asynchronous, idle high)
//   wr_en      out  one-cycle write strobe to instruction memory
//   wr_addr    out  [14:0] word address of the write
//   wr_data    out  [15:0] instruction word {hi, lo}
//   cpu_reset  out  high until the load completes
//   loaded     out  high once the load is complete
//   frame_err  out  sticky, set on any UART framing error
// -----------------------------------------------------------------------------
module rom_loader #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        wr_en,
  output logic [14:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        cpu_reset,
  output logic        loaded,
  output logic        frame_err
);

  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] MAX_WORDS = 16'd32768;

  // ---------------------------------------------------------------------------
  // Input synchronizer plus one extra flop for falling-edge detection
  // ---------------------------------------------------------------------------
  logic rx_meta_reg;
  logic rx_sync_reg;
  logic rx_prev_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // UART receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  rx_state_t   rx_state_reg, rx_state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [2:0]  bit_idx_reg, bit_idx_next;
  logic [7:0]  shift_reg, shift_next;
  logic [7:0]  rx_byte_reg, rx_byte_next;
  logic        rx_valid_reg, rx_valid_next;   // one-cycle good-byte strobe
  logic        rx_ferr_reg, rx_ferr_next;     // one-cycle framing-error strobe

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_reg <= RX_IDLE;
      cnt_reg      <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      rx_byte_reg  <= '0;
      rx_valid_reg <= 1'b0;
      rx_ferr_reg  <= 1'b0;
    end else begin
      rx_state_reg <= rx_state_next;
      cnt_reg      <= cnt_next;
      bit_idx_reg  <= bit_idx_next;
      shift_reg    <= shift_next;
      rx_byte_reg  <= rx_byte_next;
      rx_valid_reg <= rx_valid_next;
      rx_ferr_reg  <= rx_ferr_next;
    end
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    cnt_next      = cnt_reg;
    bit_idx_next  = bit_idx_reg;
    shift_next    = shift_reg;
    rx_byte_next  = rx_byte_reg;
    rx_valid_next = 1'b0;
    rx_ferr_next  = 1'b0;

    unique case (rx_state_reg)
      RX_IDLE: begin
        if (rx_prev_reg && !rx_sync_reg) begin
          rx_state_next = RX_START;
          cnt_next      = '0;
        end
      end

      // Re-check the start bit at its midpoint; a high level means the
      // falling edge was a glitch and the frame is dropped silently.
      RX_START: begin
        if (cnt_reg == HALF_M1) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          if (rx_sync_reg) begin
            rx_state_next = RX_IDLE;
          end else begin
            rx_state_next = RX_DATA;
          end
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end

      RX_DATA: begin
        if (cnt_reg == FULL_M1) begin
          cnt_next   = '0;
          shift_next = {rx_sync_reg, shift_reg[7:1]};
          if (bit_idx_reg == 3'd7) begin
            rx_state_next = RX_STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end

      RX_STOP: begin
        if (cnt_reg == FULL_M1) begin
          cnt_next      = '0;
          rx_state_next = RX_IDLE;
          if (rx_sync_reg) begin
            rx_valid_next = 1'b1;
            rx_byte_next  = shift_reg;
          end else begin
            rx_ferr_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end

      default: rx_state_next = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Protocol FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    WAIT_CNT_HI,
    WAIT_CNT_LO,
    WAIT_DAT_HI,
    WAIT_DAT_LO,
    DONE
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  hi_reg, hi_next;
  logic [15:0] remaining_reg, remaining_next;
  logic [14:0] addr_reg, addr_next;
  logic        wr_en_reg, wr_en_next;
  logic [14:0] wr_addr_reg, wr_addr_next;
  logic [15:0] wr_data_reg, wr_data_next;
  logic        frame_err_reg, frame_err_next;
  logic [15:0] word_count;

  assign word_count = {hi_reg, rx_byte_reg};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= WAIT_CNT_HI;
      hi_reg        <= '0;
      remaining_reg <= '0;
      addr_reg      <= '0;
      wr_en_reg     <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hi_reg        <= hi_next;
      remaining_reg <= remaining_next;
      addr_reg      <= addr_next;
      wr_en_reg     <= wr_en_next;
      wr_addr_reg   <= wr_addr_next;
      wr_data_reg   <= wr_data_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    hi_next        = hi_reg;
    remaining_next = remaining_reg;
    addr_next      = addr_reg;
    wr_en_next     = 1'b0;
    wr_addr_next   = wr_addr_reg;
    wr_data_next   = wr_data_reg;
    frame_err_next = frame_err_reg;

    if (rx_ferr_reg) begin
      // A corrupted byte desynchronises the stream, so the load starts over
      // from the count header. Once loaded, only the flag is updated.
      frame_err_next = 1'b1;
      if (state_reg != DONE) begin
        state_next = WAIT_CNT_HI;
        addr_next  = '0;
      end
    end else if (rx_valid_reg) begin
      unique case (state_reg)
        WAIT_CNT_HI: begin
          hi_next    = rx_byte_reg;
          state_next = WAIT_CNT_LO;
        end

        WAIT_CNT_LO: begin
          addr_next = '0;
          if (word_count == 16'd0) begin
            state_next = DONE;
          end else begin
            remaining_next = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
            state_next     = WAIT_DAT_HI;
          end
        end

        WAIT_DAT_HI: begin
          hi_next    = rx_byte_reg;
          state_next = WAIT_DAT_LO;
        end

        WAIT_DAT_LO: begin
          wr_en_next     = 1'b1;
          wr_addr_next   = addr_reg;
          wr_data_next   = {hi_reg, rx_byte_reg};
          addr_next      = addr_reg + 15'd1;
          remaining_next = remaining_reg - 16'd1;
          if (remaining_reg == 16'd1) begin
            state_next = DONE;
          end else begin
            state_next = WAIT_DAT_HI;
          end
        end

        DONE: state_next = DONE;

        default: state_next = WAIT_CNT_HI;
      endcase
    end
  end

  assign wr_en     = wr_en_reg;
  assign wr_addr   = wr_addr_reg;
  assign wr_data   = wr_data_reg;
  assign loaded    = (state_reg == DONE);
  assign cpu_reset = (state_reg != DONE);
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_rom_loader.sv
// -----------------------------------------------------------------------------
// tb_rom_loader
//   Self-checking bench for rom_loader with CLKS_PER_BIT = 4. Whole-load
//   scenarios come from a vector table; glitch, mid-load and post-load
//   corner cases are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_rom_loader;

  localparam int CPB = 4;

  logic        clk;
  logic        reset;
  logic        rx;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic [15:0] wr_data;
  logic        cpu_reset;
  logic        loaded;
  logic        frame_err;

  rom_loader #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cpu_reset (cpu_reset),
    .loaded    (loaded),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Every cycle with wr_en high is captured, so a stretched strobe shows up
  // as an extra write.
  logic [30:0] cap_q[$];

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      cap_q.push_back({wr_addr, wr_data});
      $display("write addr=%0d data=%h", wr_addr, wr_data);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cyc(CPB);
    end
    rx = stop;
    wait_cyc(CPB);
    rx = 1'b1;
    wait_cyc(2 * CPB);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    rx    = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(2);
  endtask

  typedef struct {
    string              name;
    logic [0:9][7:0]    bytes;
    int                 nbytes;
    int                 bad_idx;   // byte sent with a low stop bit, -1 none
    int                 rst_idx;   // 1-cycle reset pulse before this byte, -1 none
    int                 exp_nwr;
    logic [0:1][14:0]   exp_addr;
    logic [0:1][15:0]   exp_data;
    logic               exp_loaded;
    logic               exp_ferr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    reset = 1'b1;
    rx    = 1'b1;

    vecs[0] = '{"two_words", {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 32'h0},
                6, -1, -1, 2, {15'd0, 15'd1}, {16'h1234, 16'hABCD}, 1'b1, 1'b0};
    vecs[1] = '{"zero_count", {8'h00, 8'h00, 64'h0},
                2, -1, -1, 0, {15'd0, 15'd0}, {16'h0, 16'h0}, 1'b1, 1'b0};
    vecs[2] = '{"frame_restart", {8'h00, 8'h01, 8'h55, 8'h77, 8'h00, 8'h01, 8'hAA, 8'hBB, 16'h0},
                8, 3, -1, 1, {15'd0, 15'd0}, {16'hAABB, 16'h0}, 1'b1, 1'b1};
    vecs[3] = '{"reset_midload", {8'h00, 8'h03, 8'h11, 8'h11, 8'h22, 8'h00, 8'h01, 8'h33, 8'h44, 8'h00},
                9, -1, 5, 2, {15'd0, 15'd0}, {16'h1111, 16'h3344}, 1'b1, 1'b0};
    vecs[4] = '{"ignore_after_done", {8'h00, 8'h01, 8'h12, 8'h34, 8'h00, 8'h01, 8'hFF, 8'hFF, 16'h0},
                8, -1, -1, 1, {15'd0, 15'd0}, {16'h1234, 16'h0}, 1'b1, 1'b0};

    // Reset state while reset is held and on the cycle after release.
    wait_cyc(3);
    @(negedge clk);
    check("rst_wr_en",     {31'd0, wr_en},     32'd0);
    check("rst_wr_addr",   {17'd0, wr_addr},   32'd0);
    check("rst_wr_data",   {16'd0, wr_data},   32'd0);
    check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("rst_loaded",    {31'd0, loaded},    32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rel_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("rel_loaded",    {31'd0, loaded},    32'd0);
    check("rel_wr_en",     {31'd0, wr_en},     32'd0);

    // Table-driven complete loads.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      cap_q.delete();
      for (int k = 0; k < vecs[i].nbytes; k++) begin
        if (k == vecs[i].rst_idx) begin
          reset = 1'b1;
          wait_cyc(1);
          reset = 1'b0;
          wait_cyc(2);
        end
        send_byte(vecs[i].bytes[k], (k != vecs[i].bad_idx));
      end
      wait_cyc(10);
      @(negedge clk);
      check($sformatf("%s_nwr", vecs[i].name), cap_q.size(), vecs[i].exp_nwr);
      for (int j = 0; j < 2; j++) begin
        if (j < vecs[i].exp_nwr && j < cap_q.size()) begin
          check($sformatf("%s_addr%0d", vecs[i].name, j), {17'd0, cap_q[j][30:16]},
                {17'd0, vecs[i].exp_addr[j]});
          check($sformatf("%s_data%0d", vecs[i].name, j), {16'd0, cap_q[j][15:0]},
                {16'd0, vecs[i].exp_data[j]});
        end
      end
      check($sformatf("%s_loaded", vecs[i].name), {31'd0, loaded}, {31'd0, vecs[i].exp_loaded});
      check($sformatf("%s_cpu_reset", vecs[i].name), {31'd0, cpu_reset}, {31'd0, ~vecs[i].exp_loaded});
      check($sformatf("%s_frame_err", vecs[i].name), {31'd0, frame_err}, {31'd0, vecs[i].exp_ferr});
    end

    // One-cycle glitch while idle: nothing may change; a following 00 00
    // must then complete the load from the count state.
    do_reset();
    cap_q.delete();
    rx = 1'b0;
    wait_cyc(1);
    rx = 1'b1;
    wait_cyc(20);
    @(negedge clk);
    check("glitch_nwr",       cap_q.size(),       32'd0);
    check("glitch_frame_err", {31'd0, frame_err}, 32'd0);
    check("glitch_loaded",    {31'd0, loaded},    32'd0);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_cyc(4);
    @(negedge clk);
    check("glitch_then_load", {31'd0, loaded}, 32'd1);

    // Mid-load: CPU still in reset, last write values held while wr_en low.
    do_reset();
    cap_q.delete();
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    wait_cyc(6);
    @(negedge clk);
    check("mid_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("mid_loaded",    {31'd0, loaded},    32'd0);
    check("mid_wr_en",     {31'd0, wr_en},     32'd0);
    check("mid_hold_addr", {17'd0, wr_addr},   32'd0);
    check("mid_hold_data", {16'd0, wr_data},   32'h1234);
    check("mid_nwr",       cap_q.size(),       32'd1);

    // Framing error after the load completes sets the flag only.
    do_reset();
    cap_q.delete();
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h5A, 1'b0);
    wait_cyc(6);
    @(negedge clk);
    check("done_ferr_flag",   {31'd0, frame_err}, 32'd1);
    check("done_ferr_loaded", {31'd0, loaded},    32'd1);
    check("done_ferr_cpurst", {31'd0, cpu_reset}, 32'd0);
    check("done_ferr_nwr",    cap_q.size(),       32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
